// File: rtl/latch_write_arbiter.sv
// latch_write_arbiter
//   Shares one bank of D latches (2**ADDR_W words x DATA_W bits) between
//   N_REQ write requesters. One requester is granted at a time, and each
//   write runs as a timed sequence: D setup (1 cycle), enable pulse
//   (EN_CYCLES cycles), D hold (1 cycle, with ack). D is therefore stable
//   around both edges of every enable pulse.
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous reset, active-high
//     req       per-requester write request, held high until ack
//     req_addr  packed word addresses, requester i at [i*ADDR_W +: ADDR_W]
//     req_data  packed write data, requester i at [i*DATA_W +: DATA_W]
//     ack       one-cycle pulse to the requester whose write completed
//     busy      high whenever a write sequence is in progress
//     latch_d   shared D bus to all latch words
//     latch_en  per-word latch enable, one-hot or zero
//
//   Build option:
//     LATCH_WR_FIXED_PRIO_EN  when defined, the round-robin pointer is
//                             removed and the lowest-index active request
//                             always wins.

module latch_write_arbiter #(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned EN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic [DATA_W-1:0]         latch_d,
    output logic [(1<<ADDR_W)-1:0]    latch_en
);

    localparam int unsigned N_WORDS = 1 << ADDR_W;
    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned CNT_W   = $clog2(EN_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ENABLE,
        HOLD
    } stateT;

    stateT              state;
    logic [IDX_W-1:0]   grantReg;
    logic [ADDR_W-1:0]  addrReg;
    logic [CNT_W-1:0]   enCnt;

    logic [DATA_W-1:0]  reqDataArr [N_REQ];
    logic [ADDR_W-1:0]  reqAddrArr [N_REQ];

    logic               grantValid;
    logic [IDX_W-1:0]   grantIdx;
    logic [IDX_W-1:0]   probeIdx;

    logic [N_WORDS-1:0] wordSel;
    logic [N_REQ-1:0]   ackSel;

`ifndef LATCH_WR_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rrPtr;
    logic [IDX_W-1:0]   nextPtr;
`endif

    // Unpack the flat request buses into per-requester words
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            reqDataArr[i] = req_data[i*DATA_W +: DATA_W];
            reqAddrArr[i] = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    // Arbiter: scan requesters starting at the priority origin, first hit wins
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        probeIdx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
`ifdef LATCH_WR_FIXED_PRIO_EN
            probeIdx = IDX_W'(i);
`else
            probeIdx = IDX_W'((32'(rrPtr) + i) % N_REQ);
`endif
            if (!grantValid && req[probeIdx]) begin
                grantValid = 1'b1;
                grantIdx   = probeIdx;
            end
        end
    end

    assign wordSel = N_WORDS'(1) << addrReg;
    assign ackSel  = N_REQ'(1) << grantReg;

`ifndef LATCH_WR_FIXED_PRIO_EN
    assign nextPtr = (grantReg == IDX_W'(N_REQ - 1)) ? '0 : grantReg + 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grantReg <= '0;
            addrReg  <= '0;
            enCnt    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            latch_d  <= '0;
            latch_en <= '0;
`ifndef LATCH_WR_FIXED_PRIO_EN
            rrPtr    <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (grantValid) begin
                        // Capture everything now so later req changes cannot disturb the write
                        grantReg <= grantIdx;
                        addrReg  <= reqAddrArr[grantIdx];
                        latch_d  <= reqDataArr[grantIdx];
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    latch_en <= wordSel;
                    enCnt    <= CNT_W'(EN_CYCLES);
                    state    <= ENABLE;
                end
                ENABLE: begin
                    // enCnt counts the enable cycles still to run, including the current one
                    if (enCnt == CNT_W'(1)) begin
                        latch_en <= '0;
                        ack      <= ackSel;
                        state    <= HOLD;
                    end else begin
                        enCnt <= enCnt - 1'b1;
                    end
                end
                HOLD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifndef LATCH_WR_FIXED_PRIO_EN
                    rrPtr <= nextPtr;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb_latch_write_arbiter
//   Bench for latch_write_arbiter. A transaction-level model tracks each
//   write as "edges since grant" and derives the expected outputs from
//   that; a compare process checks every cycle on the falling edge.
//   Directed scenarios add literal expectations for timing and grant order.

module tb_latch_write_arbiter;

    localparam int N_REQ     = 4;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 2;
    localparam int EN_CYCLES = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        ack;
    logic                    busy;
    logic [DATA_W-1:0]       latch_d;
    logic [(1<<ADDR_W)-1:0]  latch_en;

    always #5 clk = ~clk;

    latch_write_arbiter #(
        .N_REQ     (N_REQ),
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .EN_CYCLES (EN_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .busy     (busy),
        .latch_d  (latch_d),
        .latch_en (latch_en)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- model ----------------
    bit          started   = 1'b0;
    bit          mActive   = 1'b0;
    bit          mAfterRst = 1'b0;
    int          mT        = 0;   // edges since the grant edge, grant edge = 1
    int          mG        = 0;
    int          mAddr     = 0;
    logic [7:0]  mData     = '0;
    int          mRr       = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            started   = 1'b1;
            mActive   = 1'b0;
            mAfterRst = 1'b1;
            mRr       = 0;
        end else begin
            mAfterRst = 1'b0;
            if (mActive) begin
                if (mT == 2 + EN_CYCLES) begin
                    mActive = 1'b0;
                    mRr     = (mG + 1) % N_REQ;
                end else begin
                    mT++;
                end
            end else begin
                for (int k = 0; k < N_REQ; k++) begin
                    int idx;
`ifdef LATCH_WR_FIXED_PRIO_EN
                    idx = k;
`else
                    idx = (mRr + k) % N_REQ;
`endif
                    if (!mActive && req[idx]) begin
                        mActive = 1'b1;
                        mT      = 1;
                        mG      = idx;
                        mAddr   = int'(req_addr[idx*ADDR_W +: ADDR_W]);
                        mData   = req_data[idx*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // ---------------- compare ----------------
    int ackLog[$];
    int ackTimes[$];

    always @(negedge clk) begin
        if (started) begin
            logic [31:0] expEn;
            logic [31:0] expAck;
            expEn  = (mActive && mT >= 2 && mT <= 1 + EN_CYCLES) ? (32'd1 << mAddr) : 32'd0;
            expAck = (mActive && mT == 2 + EN_CYCLES) ? (32'd1 << mG) : 32'd0;
            chk("busy", 32'(busy), 32'(mActive));
            chk("latch_en", 32'(latch_en), expEn);
            chk("ack", 32'(ack), expAck);
            chk("enOneHot", 32'($countones(latch_en) <= 1), 32'd1);
            if (mActive)
                chk("latch_d", 32'(latch_d), 32'(mData));
            else if (mAfterRst)
                chk("latch_d_rst", 32'(latch_d), 32'd0);
            for (int i = 0; i < N_REQ; i++) begin
                if (ack[i]) begin
                    ackLog.push_back(i);
                    ackTimes.push_back(cyc);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        ackLog.delete();
        ackTimes.delete();
    endtask

    task automatic waitAcks(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (ackLog.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, 32'(ackLog.size()), 32'(n));
    endtask

    task automatic waitEnable(input int budget, input string name);
        int k;
        k = 0;
        while (latch_en == '0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk(name, 32'(latch_en != '0), 32'd1);
    endtask

    task automatic chkOrder(input string name, input int exp[5], input int n);
        for (int i = 0; i < n; i++) begin
            if (i < ackLog.size())
                chk(name, 32'(ackLog[i]), 32'(exp[i]));
        end
        for (int i = 1; i < n; i++) begin
            if (i < ackTimes.size())
                chk("ackSpacing", 32'(ackTimes[i] - ackTimes[i-1]), 32'(EN_CYCLES + 3));
        end
    endtask

`ifdef LATCH_WR_FIXED_PRIO_EN
    int expT2[5] = '{0, 0, 0, 0, 0};
    int expT3[5] = '{0, 0, 0, 0, 0};
    int expT6[5] = '{0, 0, 0, 0, 0};
`else
    int expT2[5] = '{0, 1, 0, 1, 0};
    int expT3[5] = '{0, 1, 2, 3, 0};
    int expT6[5] = '{0, 2, 0, 2, 0};
`endif

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_addr = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rstBusy", 32'(busy), 32'd0);
        chk("rstEn", 32'(latch_en), 32'd0);
        chk("rstD", 32'(latch_d), 32'd0);
        chk("rstAck", 32'(ack), 32'd0);
        rst = 1'b0;

        // 1: single write, requester 2, word 3, data A5
        req_addr[2*ADDR_W +: ADDR_W] = 2'd3;
        req_data[2*DATA_W +: DATA_W] = 8'hA5;
        req = 4'b0100;
        @(negedge clk); #1;              // edge T: grant
        chk("t1SetupBusy", 32'(busy), 32'd1);
        chk("t1SetupEn", 32'(latch_en), 32'd0);
        chk("t1SetupD", 32'(latch_d), 32'hA5);
        @(negedge clk); #1;
        chk("t1En1", 32'(latch_en), 32'h8);
        @(negedge clk); #1;
        chk("t1En2", 32'(latch_en), 32'h8);
        chk("t1En2Ack", 32'(ack), 32'd0);
        @(negedge clk); #1;
        chk("t1HoldEn", 32'(latch_en), 32'd0);
        chk("t1HoldAck", 32'(ack), 32'b0100);
        chk("t1HoldD", 32'(latch_d), 32'hA5);
        req = '0;
        @(negedge clk); #1;
        chk("t1IdleAck", 32'(ack), 32'd0);
        chk("t1IdleBusy", 32'(busy), 32'd0);

        // 2: two requesters held high
        doReset();
        req = 4'b0011;
        waitAcks(4, 60, "t2Acks");
        req = '0;
        chkOrder("t2Order", expT2, 4);

        // 3: all requesters held high
        doReset();
        req = 4'b1111;
        waitAcks(5, 80, "t3Acks");
        req = '0;
        chkOrder("t3Order", expT3, 5);

        // 4: reset during the second enable cycle of the second write
        doReset();
        req = 4'b1111;
        waitAcks(1, 20, "t4FirstAck");
        waitEnable(20, "t4SeenEn");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("t4RstEn", 32'(latch_en), 32'd0);
        chk("t4RstD", 32'(latch_d), 32'd0);
        chk("t4RstBusy", 32'(busy), 32'd0);
        chk("t4RstAck", 32'(ack), 32'd0);
        chk("t4NoAbandonedAck", 32'(ackLog.size()), 32'd1);
        rst = 1'b0;
        waitAcks(2, 20, "t4SecondAck");
        req = '0;
        if (ackLog.size() >= 2)
            chk("t4GrantAfterRst", 32'(ackLog[1]), 32'd0);

        // 5: inputs change mid-write
        doReset();
        req_addr[1*ADDR_W +: ADDR_W] = 2'd1;
        req_data[1*DATA_W +: DATA_W] = 8'h3C;
        req = 4'b0010;
        waitEnable(20, "t5SeenEn");
        req = '0;
        req_data[1*DATA_W +: DATA_W] = 8'hFF;
        req_addr[1*ADDR_W +: ADDR_W] = 2'd2;
        waitAcks(1, 20, "t5Ack");
        chk("t5AckBit", 32'(ack), 32'b0010);
        chk("t5HoldD", 32'(latch_d), 32'h3C);

        // 6: requesters 0 and 2 held high
        doReset();
        req = 4'b0101;
        waitAcks(3, 60, "t6Acks");
        req = '0;
        chkOrder("t6Order", expT6, 3);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
